polar_encoder: RTL and testbench

Serial-in / serial-out polar encoder. It computes x = u·F^{⊗n} over N = 2^LOG_N bits, with F = [[1,0],[1,1]] and natural (non-bit-reversed) ordering. This is the same f = a^b, g = b butterfly the SC decoder's partial-sum path evaluates, run here in the forward direction. It sits at the transmit end, feeds the channel model and decoder test path, and produces the golden codewords for decoder bring-up.

---
 rtl/polar_pkg.sv | 8 +
 rtl/polar_enc_stage.sv | 28 ++
 rtl/polar_encoder.sv | 75 +++++++
 tb/tb_polar_encoder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/polar_pkg.sv
// polar_pkg: shared encoder state type and butterfly helper.
package polar_pkg;
   typedef enum logic [1:0] {ENC_LOAD, ENC_ENCODE, ENC_OUTPUT} enc_state_t;
   // Stage-s butterfly mask bit: high where index i is the xor-receiving (bit s clear) leg.
   function automatic logic bfly_mask(input int unsigned i, input int unsigned s);
      return ((i >> s) & 1) == 0;
   endfunction
endpackage

// File: rtl/polar_enc_stage.sv
// polar_enc_stage: one in-place f = a^b, g = b butterfly stage selected by stage.
module polar_enc_stage
   import polar_pkg::*;
#(
   parameter int LOG_N = 10,
   localparam int N = 2 ** LOG_N,
   localparam int STAGE_WIDTH = $clog2(LOG_N) + 1
) (
   input  logic [N-1:0]           x_in,
   input  logic [STAGE_WIDTH-1:0] stage,
   output logic [N-1:0]           x_out
);
   logic [LOG_N-1:0][N-1:0] stg;
   for (genvar s = 0; s < LOG_N; s++) begin : g_s
      for (genvar i = 0; i < N; i++) begin : g_i
         if (bfly_mask(i, s)) begin : g_u
            assign stg[s][i] = x_in[i] ^ x_in[i + (1 << s)];
         end else begin : g_l
            assign stg[s][i] = x_in[i];
         end
      end
   end
   always_comb begin
      x_out = x_in;
      for (int k = 0; k < LOG_N; k++)
         if (stage == k[STAGE_WIDTH-1:0]) x_out = stg[k];
   end
endmodule

// File: rtl/polar_encoder.sv
// polar_encoder: serial-in/serial-out x = u*F^(xn) encoder, natural order, single in-place buffer.
module polar_encoder
   import polar_pkg::*;
#(
   parameter int LOG_N = 10,
   localparam int N = 2 ** LOG_N,
   localparam int STAGE_WIDTH = $clog2(LOG_N) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             in_ready,
   output logic             out_valid,
   output logic             out_bit,
   output logic [LOG_N-1:0] out_index,
   output logic             out_last,
   input  logic             out_ready,
   output logic             busy,
   output logic             encode_fin
);
   enc_state_t state, state_nxt;
   logic [N-1:0] x, x_stage;
   logic [LOG_N-1:0] load_cnt, out_cnt;
   logic [STAGE_WIDTH-1:0] stage_cnt;
   logic in_fire, out_fire, last_stage;

   polar_enc_stage #(.LOG_N(LOG_N)) u_stage (
      .x_in (x),
      .stage(stage_cnt),
      .x_out(x_stage)
   );

   always_ff @(posedge clk) state <= reset ? ENC_LOAD : state_nxt;

   assign last_stage = stage_cnt == STAGE_WIDTH'(LOG_N - 1);

   always_comb begin
      state_nxt = (state == ENC_LOAD && in_fire && &load_cnt) ? ENC_ENCODE :
                  (state == ENC_ENCODE && last_stage) ? ENC_OUTPUT :
                  (state == ENC_OUTPUT && out_fire && out_last) ? ENC_LOAD : state;
   end

   always_comb begin
      in_ready   = state == ENC_LOAD;
      out_valid  = state == ENC_OUTPUT;
      busy       = state == ENC_ENCODE || state == ENC_OUTPUT;
      encode_fin = state == ENC_ENCODE && last_stage;
      out_bit    = out_valid && x[out_cnt];
      out_index  = out_cnt;
      out_last   = out_valid && &out_cnt;
      in_fire    = in_valid && in_ready;
      out_fire   = out_valid && out_ready;
   end

   // Counters wrap naturally at N, so each block boundary returns them to zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         x         <= '0;
         load_cnt  <= '0;
         out_cnt   <= '0;
         stage_cnt <= '0;
      end else begin
         if (in_fire) begin
            x[load_cnt] <= in_bit;
            load_cnt    <= load_cnt + 1'b1;
         end
         if (state == ENC_ENCODE) begin
            x         <= x_stage;
            stage_cnt <= last_stage ? '0 : stage_cnt + 1'b1;
         end
         if (out_fire) out_cnt <= out_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_polar_encoder.sv
// tb_polar_encoder: scoreboard bench over LOG_N = 1, 3 and 10 encoder instances.
module tb_polar_encoder;
   logic clk = 0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   int total = 0, bad = 0;
   logic go = 0, done1 = 0, done3 = 0, done10 = 0;

   logic r1 = 1, iv1 = 0, ib1 = 0, ir1, ov1, ob1, ol1, ordy1 = 1, bz1, ef1;
   logic [0:0] oi1;
   logic r3 = 1, iv3 = 0, ib3 = 0, ir3, ov3, ob3, ol3, ordy3 = 1, bz3, ef3;
   logic [2:0] oi3;
   logic r10 = 1, iv10 = 0, ib10 = 0, ir10, ov10, ob10, ol10, ordy10 = 1, bz10, ef10;
   logic [9:0] oi10;
   logic bp3 = 0, hold3 = 0, pov1 = 0, pov3 = 0, pov10 = 0;
   int q1[$], q3[$], q10[$];
   int acc1, acc3, acc10, e1, e3, e10, plast10 = 0;

   polar_encoder #(.LOG_N(1)) u1 (.clk(clk), .reset(r1), .in_valid(iv1), .in_bit(ib1), .in_ready(ir1),
      .out_valid(ov1), .out_bit(ob1), .out_index(oi1), .out_last(ol1), .out_ready(ordy1), .busy(bz1), .encode_fin(ef1));
   polar_encoder #(.LOG_N(3)) u3 (.clk(clk), .reset(r3), .in_valid(iv3), .in_bit(ib3), .in_ready(ir3),
      .out_valid(ov3), .out_bit(ob3), .out_index(oi3), .out_last(ol3), .out_ready(ordy3), .busy(bz3), .encode_fin(ef3));
   polar_encoder #(.LOG_N(10)) u10 (.clk(clk), .reset(r10), .in_valid(iv10), .in_bit(ib10), .in_ready(ir10),
      .out_valid(ov10), .out_bit(ob10), .out_index(oi10), .out_last(ol10), .out_ready(ordy10), .busy(bz10), .encode_fin(ef10));

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // out_ready pattern 1,0,0,1 under backpressure; changed away from the sampling edge
   always @(posedge clk) begin
      #1;
      ordy3 = hold3 ? 1'b0 : bp3 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
   end

   task automatic load1(input logic [1:0] u);
      for (int i = 0; i < 2; i++) begin
         iv1 = 1; ib1 = u[i];
         while (!ir1) @(negedge clk);
         acc1 = cyc;
         @(negedge clk);
      end
      iv1 = 0;
   endtask

   task automatic load3(input logic [7:0] u, input bit gaps);
      for (int i = 0; i < 8; i++) begin
         if (gaps && $urandom_range(0, 1) == 1) begin
            iv3 = 0; ib3 = 1'($urandom);
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
         iv3 = 1; ib3 = u[i];
         while (!ir3) @(negedge clk);
         acc3 = cyc;
         @(negedge clk);
      end
      iv3 = 0;
   endtask

   task automatic push3(input logic [7:0] x);
      for (int i = 0; i < 8; i++) q3.push_back(i * 2 + int'(x[i]));
   endtask

   task automatic reset_check(input string tag);
      chk({tag, "_in_ready"}, ir3, 1);
      chk({tag, "_out_valid"}, ov3, 0);
      chk({tag, "_busy"}, bz3, 0);
      chk({tag, "_encode_fin"}, ef3, 0);
      chk({tag, "_out_index"}, oi3, 0);
      chk({tag, "_out_last"}, ol3, 0);
      chk({tag, "_out_bit"}, ob3, 0);
   endtask

   always @(negedge clk) begin
      if (ov1) chk("excl1", ir1, 0);
      if (ov1 && !pov1) chk("lat1", cyc - acc1, 2);
      if (ef1) chk("fin1", cyc - acc1, 1);
      if (ov1 && ordy1) begin
         if (q1.size() == 0) chk("extra1", q1.size(), 1);
         else begin
            e1 = q1.pop_front();
            chk("idx1", oi1, e1 >> 1); chk("bit1", ob1, e1 & 1); chk("last1", ol1, int'((e1 >> 1) == 1));
         end
      end
      pov1 = ov1;
   end

   always @(negedge clk) begin
      if (ov3) chk("excl3", ir3, 0);
      if (ov3 && !pov3) chk("lat3", cyc - acc3, 4);
      if (ef3) chk("fin3", cyc - acc3, 3);
      if (ov3 && ordy3) begin
         if (q3.size() == 0) chk("extra3", q3.size(), 1);
         else begin
            e3 = q3.pop_front();
            chk("idx3", oi3, e3 >> 1); chk("bit3", ob3, e3 & 1); chk("last3", ol3, int'((e3 >> 1) == 7));
         end
      end
      pov3 = ov3;
   end

   always @(negedge clk) begin
      if (ov10 && !pov10) chk("lat10", cyc - acc10, 11);
      if (ef10) chk("fin10", cyc - acc10, 10);
      if (ov10 && ordy10) begin
         if (q10.size() == 0) chk("extra10", q10.size(), 1);
         else begin
            e10 = q10.pop_front();
            chk("idx10", oi10, e10 >> 1); chk("bit10", ob10, e10 & 1); chk("last10", ol10, int'((e10 >> 1) == 1023));
         end
         if (ol10) begin
            if (plast10 != 0) chk("space10", cyc - plast10, 2 * 1024 + 10);
            plast10 = cyc;
         end
      end
      pov10 = ov10;
   end

   initial begin : seq1
      wait (go); @(negedge clk);
      q1.push_back(0); q1.push_back(3); load1(2'b11);
      q1.push_back(1); q1.push_back(2); load1(2'b01);
      q1.push_back(1); q1.push_back(3); load1(2'b10);
      wait (q1.size() == 0); repeat (3) @(negedge clk);
      done1 = 1;
   end

   initial begin : seq3
      wait (go); @(negedge clk);
      push3(8'h01); load3(8'h01, 0);
      push3(8'hFF); load3(8'h80, 0);
      push3(8'h11); load3(8'h10, 0);
      push3(8'h80); load3(8'hFF, 0);
      push3(8'h08); load3(8'h0F, 0);
      bp3 = 1;
      push3(8'hC8); load3(8'hA5, 1);
      wait (q3.size() == 0); repeat (3) @(negedge clk);
      bp3 = 0;
      load3(8'hFF, 0);
      @(negedge clk);
      r3 = 1; q3.delete();
      @(negedge clk);
      reset_check("rst_enc");
      r3 = 0;
      push3(8'hC8); load3(8'hA5, 0);
      wait (q3.size() <= 4);
      hold3 = 1;
      @(negedge clk);
      r3 = 1; q3.delete();
      @(negedge clk);
      reset_check("rst_out");
      r3 = 0; hold3 = 0;
      push3(8'h11); load3(8'h10, 0);
      wait (q3.size() == 0); repeat (3) @(negedge clk);
      done3 = 1;
   end

   initial begin : seq10
      logic [1023:0] u;
      logic xb;
      wait (go); @(negedge clk);
      for (int b = 0; b < 20; b++) begin
         for (int i = 0; i < 1024; i++) u[i] = 1'($urandom);
         for (int j = 0; j < 1024; j++) begin
            xb = 0;
            for (int i = 0; i < 1024; i++) if ((i & j) == j) xb ^= u[i];
            q10.push_back(j * 2 + int'(xb));
         end
         for (int i = 0; i < 1024; i++) begin
            iv10 = 1; ib10 = u[i];
            while (!ir10) @(negedge clk);
            acc10 = cyc;
            @(negedge clk);
         end
      end
      iv10 = 0;
      wait (q10.size() == 0); repeat (3) @(negedge clk);
      done10 = 1;
   end

   initial begin : main
      repeat (2) @(negedge clk);
      reset_check("rst_init");
      chk("rst_init_ready1", ir1, 1);
      chk("rst_init_ready10", ir10, 1);
      r1 = 0; r3 = 0; r10 = 0;
      go = 1;
      fork
         wait (done1 && done3 && done10);
         #900_000;
      join_any
      disable fork;
      chk("all_done", int'(done1 && done3 && done10), 1);
      chk("drain1", q1.size(), 0);
      chk("drain3", q3.size(), 0);
      chk("drain10", q10.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
